// File: rtl/sec_alu_seq.sv
// Secondary ALU sequencer: owns HI/LO, runs the external iterative mul/div unit
// over a start/done handshake and stalls decode while that unit is busy.
module sec_alu_seq #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_sec_alu_en,
    input  logic [2:0]            i_sec_alu_op,
    input  logic [DATA_WIDTH-1:0] i_rs_data,
    input  logic [DATA_WIDTH-1:0] i_rt_data,
    input  logic                  i_kill,
    output logic                  o_stall_en,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_start,
    output logic [1:0]            o_unit_op,
    output logic [DATA_WIDTH-1:0] o_unit_a,
    output logic [DATA_WIDTH-1:0] o_unit_b,
    input  logic                  i_unit_done,
    input  logic [DATA_WIDTH-1:0] i_unit_hi,
    input  logic [DATA_WIDTH-1:0] i_unit_lo,
    output logic                  o_busy,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic                  o_timeout,
    output logic                  o_div_zero
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]        OP_MTHI  = 3'd4;
    localparam logic [2:0]        OP_MTLO  = 3'd5;
    localparam logic [2:0]        OP_MFHI  = 3'd6;
    localparam logic [2:0]        OP_MFLO  = 3'd7;

    // Handshake: a request transfers when i_sec_alu_en & ~i_kill is high and
    // o_stall_en is low in the same cycle; o_start/i_unit_done are one-cycle
    // pulses, and a done seen outside BUSY carries no meaning.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             req, accept, is_unit_op, div_by_zero, start_unit;
    logic             last_cycle, timeout_hit, done_hit;

    assign req         = i_sec_alu_en & ~i_kill;
    assign accept      = req & (state_q == IDLE);
    assign is_unit_op  = ~i_sec_alu_op[2];
    assign div_by_zero = is_unit_op & i_sec_alu_op[1] & (i_rt_data == '0);
    assign start_unit  = accept & is_unit_op & ~div_by_zero;
    assign last_cycle  = (cnt_q == CNT_LAST);
    assign done_hit    = (state_q == BUSY) & i_unit_done;
    // Done takes priority over the timeout in the final BUSY cycle.
    assign timeout_hit = (state_q == BUSY) & ~i_unit_done & last_cycle;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_unit) state_d = BUSY;
            BUSY: if (done_hit || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (state_q == BUSY);
        o_stall_en = req & (state_q != IDLE);
        o_result   = '0;
        if (i_sec_alu_op == OP_MFHI) o_result = o_hi;
        if (i_sec_alu_op == OP_MFLO) o_result = o_lo;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cnt_q      <= '0;
            o_start    <= 1'b0;
            o_timeout  <= 1'b0;
            o_div_zero <= 1'b0;
            o_unit_op  <= 2'd0;
            o_unit_a   <= '0;
            o_unit_b   <= '0;
            o_hi       <= '0;
            o_lo       <= '0;
        end else begin
            o_start    <= start_unit;
            o_timeout  <= timeout_hit;
            o_div_zero <= accept & div_by_zero;
            if (start_unit) begin
                cnt_q     <= '0;
                o_unit_op <= i_sec_alu_op[1:0];
                o_unit_a  <= i_rs_data;
                o_unit_b  <= i_rt_data;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (done_hit) begin
                o_hi <= i_unit_hi;
                o_lo <= i_unit_lo;
            end else if (accept && i_sec_alu_op == OP_MTHI) begin
                o_hi <= i_rs_data;
            end else if (accept && i_sec_alu_op == OP_MTLO) begin
                o_lo <= i_rs_data;
            end
        end
    end

endmodule

// File: doc/sec_alu_seq.md
# sec_alu_seq

Sequencer for the secondary (multiply/divide) ALU in the execute stage. It accepts mul/div/move operations flagged by decode, owns the HI/LO registers, and starts and collects the external iterative mul/div unit over a start/done handshake. It back-pressures the pipeline through the stall line that decode receives as `i_stall_en`.

## Interface

**Parameters**
- `DATA_WIDTH`, 32: operand and HI/LO width.
- `TIMEOUT_CYCLES`, 64: maximum BUSY cycles before abort (≥2).

**Ports**
- `i_clk` in 1: clock.
- `i_arst_n` in 1: reset, asynchronous, active-low.
- `i_sec_alu_en` in 1: request valid; registered `o_sec_alu_en` from decode.
- `i_sec_alu_op` in 3: op code. 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- `i_rs_data`, `i_rt_data` in `DATA_WIDTH`: operands.
- `i_kill` in 1: drop the request presented this cycle (interrupt/flush).
- `o_stall_en` out 1: combinational; request cannot be accepted this cycle.
- `o_result` out `DATA_WIDTH`: combinational; HI for MFHI, LO for MFLO, else 0.
- `o_start` out 1: one-cycle pulse that starts the unit.
- `o_unit_op` out 2: latched `i_sec_alu_op[1:0]`.
- `o_unit_a`, `o_unit_b` out `DATA_WIDTH`: latched rs/rt.
- `i_unit_done` in 1: unit result valid, single-cycle pulse.
- `i_unit_hi`, `i_unit_lo` in `DATA_WIDTH`: unit result.
- `o_busy` out 1: state is BUSY.
- `o_hi`, `o_lo` out `DATA_WIDTH`: architectural HI/LO.
- `o_timeout`, `o_div_zero` out 1: one-cycle error pulses.

## Operation
- **Reset values:** state IDLE; `o_hi`, `o_lo`, `o_unit_a`, `o_unit_b` = 0; `o_unit_op` = 0; `o_start`, `o_timeout`, `o_div_zero`, `o_busy` = 0; timeout counter = 0.
- **Acceptance:** a request is accepted when `req = i_sec_alu_en & ~i_kill` and `o_stall_en = 0`.
- **Stall:** `o_stall_en = req & (state != IDLE)`. Every op stalls while BUSY, including MFHI/MFLO and MTHI/MTLO.
- **IDLE, op 0–3 with a nonzero divisor (or MULT/MULTU):** latch `o_unit_a/b/op`, assert `o_start` next cycle, go to BUSY, clear counter.
- **IDLE, DIV/DIVU with `i_rt_data == 0`:** no start; HI/LO unchanged; `o_div_zero` pulses next cycle; stay IDLE.
- **IDLE, MTHI/MTLO:** HI (or LO) ← `i_rs_data` at the clock edge.
- **IDLE, MFHI/MFLO:** `o_result` = `o_hi`/`o_lo` in the same cycle; no state change.
- **BUSY:**
  - Counter increments every cycle.
  - On `i_unit_done`: {HI, LO} ← {`i_unit_hi`, `i_unit_lo`}, go to IDLE.
  - When the counter reaches `TIMEOUT_CYCLES - 1` without done: `o_timeout` pulses, HI/LO unchanged, go to IDLE.
  - Done wins if it arrives in that same cycle.
- **`i_unit_done` while IDLE:** ignored.
- **`i_kill`:** affects only the current request. An operation already BUSY runs to completion.
- **Reset mid-BUSY:** everything returns to reset values immediately; a later `i_unit_done` is ignored.

## Timing
- Accept at edge t → `o_start` = 1 during cycle t+1 only; `o_busy` = 1 from t+1.
- Unit done sampled at edge d → `o_hi/o_lo` updated and `o_busy` = 0 after d. A request stalled in cycle d is accepted at edge d+1; there is no forwarding of the new HI/LO.
- Minimum back-to-back mul latency is 1 BUSY cycle (done in cycle t+1).
- MTHI/MTLO: visible on `o_hi/o_lo` and `o_result` in the cycle after acceptance.
- MTHI/MTLO followed immediately by MFHI/MFLO reads the new value with no stall.
- Error pulses last exactly one cycle, in the cycle after the triggering edge.

## Test plan
- **Reset:** assert `i_arst_n` = 0 mid-cycle → all outputs 0 asynchronously; MFLO after release → `o_result` = 0.
- **MULT handshake:** MULT rs=7, rt=6 → `o_start` for 1 cycle with a=7, b=6, op=0; unit done after 3 cycles with hi=0, lo=42 → `o_lo` = 42; MFLO issued during BUSY stalls (`o_stall_en` = 1 each cycle) and then returns 42.
- **Move ops:** MTHI 0xDEADBEEF, then MFHI next cycle → `o_result` = 0xDEADBEEF with `o_stall_en` = 0 throughout.
- **Divide by zero:** DIVU rs=10, rt=0 → no `o_start`; `o_div_zero` pulse; HI/LO keep prior values.
- **Timeout:** start MULT with no done (`TIMEOUT_CYCLES` = 8) → `o_timeout` pulse after 8 BUSY cycles, IDLE, HI/LO unchanged; a late done is ignored.
- **Kill and simultaneous events:**
  - `i_kill` together with MTLO 5 → LO unchanged.
  - Done arriving in the timeout cycle → result written, no `o_timeout`.
